// File: rtl/rtio_pkg.sv
// Shared RTIO definitions: FIFO entry layout, field helpers and scheduler states.
package rtio_pkg;

  localparam int TIMESTAMP_WIDTH = 64;
  localparam int VALUE_WIDTH     = 4;
  localparam int ENTRY_WIDTH     = TIMESTAMP_WIDTH + VALUE_WIDTH;

  typedef logic [TIMESTAMP_WIDTH-1:0] ts_t;
  typedef logic [VALUE_WIDTH-1:0]     val_t;
  typedef logic [ENTRY_WIDTH-1:0]     entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  function automatic ts_t ts_of(input entry_t e);
    return e[ENTRY_WIDTH-1:VALUE_WIDTH];
  endfunction

  function automatic val_t value_of(input entry_t e);
    return e[VALUE_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/rtio_timestamp_counter.sv
// Free-running local timestamp; wraps modulo 2^WIDTH.
module rtio_timestamp_counter
  import rtio_pkg::*;
#(
  parameter int WIDTH = TIMESTAMP_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] time_now
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else     r_cnt <= r_cnt + 1'b1;
  end

  assign time_now = r_cnt;

endmodule

// File: rtl/rtio_output_scheduler.sv
// Holds one FIFO entry until the local time reaches its timestamp, then strobes
// its value out; entries already due or past when popped are dropped as underflow.
module rtio_output_scheduler
  import rtio_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       fifo_empty,
  input  logic [ENTRY_WIDTH-1:0]     fifo_dout,
  output logic                       fifo_rd_en,
  input  logic                       err_clear,
  output logic [VALUE_WIDTH-1:0]     out_value,
  output logic                       out_stb,
  output logic                       underflow,
  output logic                       busy,
  output logic [TIMESTAMP_WIDTH-1:0] time_now
);

  state_t r_state;
  state_t w_next;
  ts_t    r_ts;
  val_t   r_val;
  val_t   r_out_value;
  logic   r_out_stb;
  logic   r_underflow;
  ts_t    w_time;
  logic   w_fire;
  logic   w_pop;
  logic   w_late;
  logic   w_hold;

  rtio_timestamp_counter #(
    .WIDTH(TIMESTAMP_WIDTH)
  ) u_tsc (
    .clk      (clk),
    .rst      (rst),
    .time_now (w_time)
  );

  assign w_fire = (r_state == WAIT) && (w_time == r_ts);
  assign w_pop  = enable && !fifo_empty && !rst
               && ((r_state == IDLE) || w_fire);
  // Classified against the pre-edge time, so ts == now is already too late.
  assign w_late = (ts_of(fifo_dout) <= w_time);
  assign w_hold = w_pop && !w_late;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (w_hold) w_next = WAIT;
      WAIT: if (w_fire) w_next = w_hold ? WAIT : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy       = (r_state == WAIT);
    fifo_rd_en = w_pop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ts        <= '0;
      r_val       <= '0;
      r_out_value <= '0;
      r_out_stb   <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_out_stb <= w_fire;
      if (w_fire) r_out_value <= r_val;
      if (w_hold) begin
        r_ts  <= ts_of(fifo_dout);
        r_val <= value_of(fifo_dout);
      end
      if (w_pop && w_late) r_underflow <= 1'b1;
      else if (err_clear)  r_underflow <= 1'b0;
    end
  end

  assign out_value = r_out_value;
  assign out_stb   = r_out_stb;
  assign underflow = r_underflow;
  assign time_now  = w_time;

endmodule
